// File: rtl/xor_net_sequencer_if.sv
// rtl/xor_net_sequencer_if.sv - host/neuron signal bundle for the XOR network sequencer
//
// Purpose: carries the input-pair handshake, the neuron Run/En/Ready/data lines
// and the result handshake between the host side and xor_net_sequencer.
// Modports:
//   master - host and neuron side (drives in_*, hid_rdy_*, hid_y_*, out_rdy, out_y, res_ready)
//   slave  - the sequencer itself (drives in_ready, nrn_en, *_run, *_x*, res_*, busy, timeout_err)
interface xor_net_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_x1;
  logic signed [DATA_WIDTH-1:0] in_x2;
  logic                         nrn_en;
  logic                         hid_run;
  logic signed [DATA_WIDTH-1:0] hid_x1;
  logic signed [DATA_WIDTH-1:0] hid_x2;
  logic                         hid_rdy_a;
  logic                         hid_rdy_b;
  logic signed [DATA_WIDTH-1:0] hid_y_a;
  logic signed [DATA_WIDTH-1:0] hid_y_b;
  logic                         out_run;
  logic signed [DATA_WIDTH-1:0] out_x1;
  logic signed [DATA_WIDTH-1:0] out_x2;
  logic                         out_rdy;
  logic signed [DATA_WIDTH-1:0] out_y;
  logic                         res_valid;
  logic                         res_ready;
  logic signed [DATA_WIDTH-1:0] res_y;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    output in_valid, in_x1, in_x2, hid_rdy_a, hid_rdy_b, hid_y_a, hid_y_b,
           out_rdy, out_y, res_ready,
    input  in_ready, nrn_en, hid_run, hid_x1, hid_x2, out_run, out_x1, out_x2,
           res_valid, res_y, busy, timeout_err
  );

  modport slave (
    input  in_valid, in_x1, in_x2, hid_rdy_a, hid_rdy_b, hid_y_a, hid_y_b,
           out_rdy, out_y, res_ready,
    output in_ready, nrn_en, hid_run, hid_x1, hid_x2, out_run, out_x1, out_x2,
           res_valid, res_y, busy, timeout_err
  );
endinterface

// File: rtl/xor_net_sequencer.sv
// rtl/xor_net_sequencer.sv - sequences the two hidden neurons and the output neuron of the XOR network
//
// Purpose: accepts an input pair, runs both hidden neurons in parallel, feeds their
// results to the output neuron and returns its Y over a valid/ready handshake.
// Optional feature macro: XOR_SEQ_TIMEOUT_EN (wait-state watchdog, sets timeout_err).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (aborts any operation in flight)
//   bus  - xor_net_sequencer_if.slave: in_* pair handshake, hid_*/out_* neuron lines,
//          res_* result handshake, nrn_en, busy, timeout_err
module xor_net_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst,
  xor_net_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN_HID  = 3'd1;
  localparam logic [2:0] S_WAIT_HID = 3'd2;
  localparam logic [2:0] S_RUN_OUT  = 3'd3;
  localparam logic [2:0] S_WAIT_OUT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hid_x1_q, hid_x1_d, hid_x2_q, hid_x2_d;
  logic [DATA_WIDTH-1:0] out_x1_q, out_x1_d, out_x2_q, out_x2_d;
  logic [DATA_WIDTH-1:0] res_y_q, res_y_d;
  logic                  fa_q, fa_d, fb_q, fb_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  hid_run_q, out_run_q, res_valid_q;
  logic                  hid_done;
  logic                  timeout_hit;

  // Ready pulses may land in different cycles; the sticky flags remember the
  // earlier one, the live pulse covers the later one.
  assign hid_done = (fa_q | bus.hid_rdy_a) & (fb_q | bus.hid_rdy_b);

`ifdef XOR_SEQ_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds (wait cycles elapsed - 1); hitting CNT_LAST means this is
  // the TIMEOUT_CYCLES-th wait cycle.
  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    hid_x1_d      = hid_x1_q;
    hid_x2_d      = hid_x2_q;
    out_x1_d      = out_x1_q;
    out_x2_d      = out_x2_q;
    res_y_d       = res_y_q;
    fa_d          = fa_q;
    fb_d          = fb_q;
    timeout_err_d = timeout_err_q;
`ifdef XOR_SEQ_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          hid_x1_d      = bus.in_x1;
          hid_x2_d      = bus.in_x2;
          timeout_err_d = 1'b0;
          state_d       = S_RUN_HID;
        end
      end
      S_RUN_HID: begin
        fa_d    = 1'b0;
        fb_d    = 1'b0;
`ifdef XOR_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT_HID;
      end
      S_WAIT_HID: begin
        fa_d = fa_q | bus.hid_rdy_a;
        fb_d = fb_q | bus.hid_rdy_b;
        // Completion is checked before the limit so a Ready on the last cycle wins.
        if (hid_done) begin
          out_x1_d = bus.hid_y_a;
          out_x2_d = bus.hid_y_b;
          state_d  = S_RUN_OUT;
        end else if (timeout_hit) begin
          res_y_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
`ifdef XOR_SEQ_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
      end
      S_RUN_OUT: begin
`ifdef XOR_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (bus.out_rdy) begin
          res_y_d = bus.out_y;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          res_y_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
`ifdef XOR_SEQ_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
      end
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hid_x1_q      <= '0;
      hid_x2_q      <= '0;
      out_x1_q      <= '0;
      out_x2_q      <= '0;
      res_y_q       <= '0;
      fa_q          <= 1'b0;
      fb_q          <= 1'b0;
      timeout_err_q <= 1'b0;
      hid_run_q     <= 1'b0;
      out_run_q     <= 1'b0;
      res_valid_q   <= 1'b0;
`ifdef XOR_SEQ_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hid_x1_q      <= hid_x1_d;
      hid_x2_q      <= hid_x2_d;
      out_x1_q      <= out_x1_d;
      out_x2_q      <= out_x2_d;
      res_y_q       <= res_y_d;
      fa_q          <= fa_d;
      fb_q          <= fb_d;
      timeout_err_q <= timeout_err_d;
      // Strobes are registered from the next state so they line up with the state.
      hid_run_q     <= (state_d == S_RUN_HID);
      out_run_q     <= (state_d == S_RUN_OUT);
      res_valid_q   <= (state_d == S_DONE);
`ifdef XOR_SEQ_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.nrn_en      = 1'b1;
  assign bus.hid_run     = hid_run_q;
  assign bus.hid_x1      = hid_x1_q;
  assign bus.hid_x2      = hid_x2_q;
  assign bus.out_run     = out_run_q;
  assign bus.out_x1      = out_x1_q;
  assign bus.out_x2      = out_x2_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_y       = res_y_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_xor_net_sequencer.sv
// tb/tb_xor_net_sequencer.sv - directed self-checking bench for xor_net_sequencer
module tb_xor_net_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_net_sequencer_if #(.DATA_WIDTH(8)) bus ();

  xor_net_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural neuron stand-ins: Ready pulses 7 cycles after the Run cycle
  // (hidden delays adjustable; 0 = never), Y holds after the pulse.
  int da = 7, db = 7, ca, cb, co;
  logic stub = 1'b0;
  logic signed [7:0] stub_ya, stub_yb, ya_p, yb_p, yo_p;
  logic ra_m, spur_a = 1'b0;
  assign bus.hid_rdy_a = ra_m | spur_a;

  function automatic logic signed [7:0] thr(input int s, input int t);
    return (s > t) ? 8'sd16 : 8'sd0;
  endfunction

  always @(negedge clk) begin
    ra_m = 1'b0;
    bus.hid_rdy_b = 1'b0;
    bus.out_rdy = 1'b0;
    if (rst) begin
      ca = 0; cb = 0; co = 0;
      bus.hid_y_a = 8'sd0; bus.hid_y_b = 8'sd0; bus.out_y = 8'sd0;
    end else begin
      if (ca > 0) begin ca--; if (ca == 0) begin ra_m = 1'b1; bus.hid_y_a = stub ? stub_ya : ya_p; end end
      if (cb > 0) begin cb--; if (cb == 0) begin bus.hid_rdy_b = 1'b1; bus.hid_y_b = stub ? stub_yb : yb_p; end end
      if (co > 0) begin co--; if (co == 0) begin bus.out_rdy = 1'b1; bus.out_y = yo_p; end end
      if (bus.hid_run) begin
        ca = da; cb = db;
        ya_p = thr(int'(bus.hid_x1) + int'(bus.hid_x2), 8);
        yb_p = thr(int'(bus.hid_x1) + int'(bus.hid_x2), 24);
      end
      if (bus.out_run) begin
        co = 7;
        yo_p = thr(int'(bus.out_x1) - int'(bus.out_x2), 8);
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge where res_valid is first seen.
  task automatic run_pair(input logic signed [7:0] x1, input logic signed [7:0] x2,
                          input logic signed [7:0] exp_y, input int exp_lat, input int exp_orun);
    int lat = -1, hr = 0, first_hr = -1, first_or = -1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL pair_in_ready: got %b expected 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_x1 = x1; bus.in_x2 = x2;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) bus.in_valid = 1'b0;
      if (bus.hid_run === 1'b1) begin hr++; if (first_hr < 0) first_hr = n; end
      if (bus.out_run === 1'b1 && first_or < 0) first_or = n;
      if (bus.res_valid === 1'b1) lat = n;
    end
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL latency (%0d,%0d): got %0d expected %0d", x1, x2, lat, exp_lat); end
    n_checks++; if (first_hr != 1 || hr != 1) begin n_fail++; $display("FAIL hid_run_pulse: first %0d count %0d expected 1/1", first_hr, hr); end
    n_checks++; if (first_or != exp_orun) begin n_fail++; $display("FAIL out_run_cycle: got %0d expected %0d", first_or, exp_orun); end
    n_checks++; if (bus.res_y !== exp_y) begin n_fail++; $display("FAIL res_y (%0d,%0d): got %0d expected %0d", x1, x2, bus.res_y, exp_y); end
    n_checks++; if (bus.hid_x1 !== x1 || bus.hid_x2 !== x2) begin n_fail++; $display("FAIL hid_x: got %0d,%0d expected %0d,%0d", bus.hid_x1, bus.hid_x2, x1, x2); end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.nrn_en !== 1'b1) begin n_fail++; $display("FAIL rst_nrn_en: got %b expected 1", bus.nrn_en); end
    n_checks++; if ({bus.hid_run, bus.out_run, bus.res_valid, bus.busy, bus.timeout_err} !== 5'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b expected 00000", {bus.hid_run, bus.out_run, bus.res_valid, bus.busy, bus.timeout_err}); end
    n_checks++; if ({bus.hid_x1, bus.hid_x2, bus.out_x1, bus.out_x2, bus.res_y} !== 40'd0) begin
      n_fail++; $display("FAIL rst_data: got %h expected 0", {bus.hid_x1, bus.hid_x2, bus.out_x1, bus.out_x2, bus.res_y}); end
  endtask

  task automatic test_back_to_back();
    run_pair(8'sd0,  8'sd0,  8'sd0,  17, 9); @(negedge clk);
    run_pair(8'sd0,  8'sd16, 8'sd16, 17, 9); @(negedge clk);
    run_pair(8'sd16, 8'sd0,  8'sd16, 17, 9); @(negedge clk);
    run_pair(8'sd16, 8'sd16, 8'sd0,  17, 9); @(negedge clk);
  endtask

  task automatic test_skewed_ready();
    stub = 1'b1; stub_ya = 8'sh11; stub_yb = 8'sh22; db = 10;
    run_pair(8'sd16, 8'sd0, 8'sd0, 20, 12);
    n_checks++; if (bus.out_x1 !== 8'sh11 || bus.out_x2 !== 8'sh22) begin
      n_fail++; $display("FAIL skew_out_x: got %h,%h expected 11,22", bus.out_x1, bus.out_x2); end
    stub = 1'b0; db = 7;
    @(negedge clk);
  endtask

  task automatic test_hold_result();
    logic signed [7:0] held;
    bus.res_ready = 1'b0;
    run_pair(8'sd0, 8'sd16, 8'sd16, 17, 9);
    held = bus.res_y;
    bus.in_valid = 1'b1; bus.in_x1 = 8'sd5; bus.in_x2 = 8'sd6;
    for (int i = 0; i < 5; i++) begin
      spur_a = (i == 1);
      @(negedge clk);
      n_checks++; if (bus.res_valid !== 1'b1 || bus.res_y !== held) begin
        n_fail++; $display("FAIL hold_res: valid %b y %0d expected 1/%0d", bus.res_valid, bus.res_y, held); end
      n_checks++; if (bus.in_ready !== 1'b0 || bus.hid_run !== 1'b0 || bus.out_run !== 1'b0) begin
        n_fail++; $display("FAIL hold_quiet: in_ready %b hid_run %b out_run %b expected 000", bus.in_ready, bus.hid_run, bus.out_run); end
    end
    spur_a = 1'b0; bus.res_ready = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: in_ready %b res_valid %b expected 1/0", bus.in_ready, bus.res_valid); end
    n_checks++; if (bus.hid_x1 !== 8'sd0 || bus.hid_x2 !== 8'sd16) begin
      n_fail++; $display("FAIL hold_ignored_in: got %0d,%0d expected 0,16", bus.hid_x1, bus.hid_x2); end
  endtask

  task automatic test_spurious_idle();
    spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.hid_run !== 1'b0 || bus.out_run !== 1'b0) begin
        n_fail++; $display("FAIL spur_idle: busy %b in_ready %b hid_run %b out_run %b expected 0100", bus.busy, bus.in_ready, bus.hid_run, bus.out_run); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
`ifdef XOR_SEQ_TIMEOUT_EN
    db = 0;
    run_pair(8'sd0, 8'sd16, 8'sd0, 17, -1);
    n_checks++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b expected 1", bus.timeout_err); end
    db = 7;
    @(negedge clk);
    n_checks++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_hold: got %b expected 1", bus.timeout_err); end
    run_pair(8'sd16, 8'sd0, 8'sd16, 17, 9);
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b expected 0", bus.timeout_err); end
    @(negedge clk);
`else
    logic seen_or = 1'b0;
    db = 0;
    bus.in_valid = 1'b1; bus.in_x1 = 8'sd0; bus.in_x2 = 8'sd16;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) bus.in_valid = 1'b0;
      if (bus.out_run === 1'b1) seen_or = 1'b1;
    end
    n_checks++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0 || seen_or !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout_wait: busy %b res_valid %b out_run_seen %b expected 100", bus.busy, bus.res_valid, seen_or); end
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL no_timeout_err: got %b expected 0", bus.timeout_err); end
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    db = 7;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_x1 = 8'sd16; bus.in_x2 = 8'sd16;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) bus.in_valid = 1'b0;
    end
    n_checks++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_busy: busy %b res_valid %b expected 1/0", bus.busy, bus.res_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: in_ready %b res_valid %b busy %b expected 1/0/0", bus.in_ready, bus.res_valid, bus.busy); end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.out_run !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: in_ready %b res_valid %b out_run %b expected 1/0/0", bus.in_ready, bus.res_valid, bus.out_run); end
    run_pair(8'sd16, 8'sd0, 8'sd16, 17, 9);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_x1 = 8'sd0; bus.in_x2 = 8'sd0; bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_skewed_ready();
    test_hold_result();
    test_spurious_idle();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
